// File: rtl/fifo_rd_pkg.sv
// Shared definitions for the async FIFO read-side stream adapter.
// Holds the Galois LFSR tap table and step function used by the optional
// sequence checker (FIFO_RD_SEQ_CHECK_EN) and by the write-side generator.
package fifo_rd_pkg;

    // Maximal-length Galois LFSR taps, one constant per supported width.
    localparam logic [7:0]  LFSR_TAPS_8  = 8'hB8;
    localparam logic [15:0] LFSR_TAPS_16 = 16'hB400;
    localparam logic [31:0] LFSR_TAPS_32 = 32'h80200003;

    // Tap mask for a given width, zero-extended to 32 bits; 0 marks an unsupported width.
    function automatic logic [31:0] lfsr_taps(input int width);
        case (width)
            8:       return {24'h0, LFSR_TAPS_8};
            16:      return {16'h0, LFSR_TAPS_16};
            32:      return LFSR_TAPS_32;
            default: return 32'h0;
        endcase
    endfunction

    // One Galois step: shift right, fold the taps in when the bit shifted out is 1.
    // Operands are zero-extended, so narrower LFSRs work unchanged in the low bits.
    function automatic logic [31:0] lfsr_next(input logic [31:0] value, input logic [31:0] taps);
        return (value >> 1) ^ (value[0] ? taps : 32'h0);
    endfunction

    // An all-zero seed would lock the LFSR at zero forever.
    function automatic bit lfsr_seed_ok(input logic [31:0] seed);
        return seed != 32'h0;
    endfunction

endpackage

// File: rtl/fifo_rd_lfsr.sv
// Galois LFSR with synchronous seed load and an advance enable.
// Used as the expected-sequence source of the read-side checker and as the
// pattern source of the matching write-side generator.
module fifo_rd_lfsr
    import fifo_rd_pkg::*;
#(
    parameter int               WIDTH = 8,
    parameter logic [WIDTH-1:0] SEED  = '1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             advance,
    output logic [WIDTH-1:0] value
);

    localparam logic [31:0] TAPS = lfsr_taps(WIDTH);

    // Seed on reset, otherwise step once per advance request.
    always_ff @(posedge clk) begin
        if (rst) begin
            value <= SEED;
        end else if (advance) begin
            value <= WIDTH'(lfsr_next(32'(value), TAPS));
        end
    end

endmodule

// File: rtl/fifo_rd_stream.sv
// Read-side consumer of the async FIFO: issues rd_en, captures Data_out one
// cycle later into a small ring buffer, and presents it as a valid/ready
// stream. The buffer reserves a slot for every outstanding read, so
// backpressure never drops or duplicates a word.
// Optional feature: define FIFO_RD_SEQ_CHECK_EN to compare each captured word
// against an LFSR sequence (seq_err / err_count); otherwise both are tied to 0.
module fifo_rd_stream
    import fifo_rd_pkg::*;
#(
    parameter int                   DATA_BITS = 8,
    parameter int                   BUF_DEPTH = 4,
    parameter int                   CNT_BITS  = 16,
    parameter logic [DATA_BITS-1:0] LFSR_SEED = DATA_BITS'(8'h5A)
) (
    input  logic                 rd_clk,
    input  logic                 rd_rst,
    input  logic                 empty,
    output logic                 rd_en,
    input  logic [DATA_BITS-1:0] Data_out,
    output logic [DATA_BITS-1:0] m_data,
    output logic                 m_valid,
    input  logic                 m_ready,
    output logic [CNT_BITS-1:0]  words_rcvd,
    output logic                 seq_err,
    output logic [CNT_BITS-1:0]  err_count
);

    localparam int                PTR_BITS  = $clog2(BUF_DEPTH);
    localparam logic [PTR_BITS:0] DEPTH_VAL = (PTR_BITS + 1)'(BUF_DEPTH);

    logic [DATA_BITS-1:0] buffer [BUF_DEPTH];
    logic [PTR_BITS-1:0]  wr_ptr;
    logic [PTR_BITS-1:0]  rd_ptr;
    logic [PTR_BITS:0]    count;
    logic [PTR_BITS:0]    occupancy;
    logic                 inflight;
    logic                 pop;

    // A zero seed is unusable; this empty block flags such a build in the hierarchy.
    if (!lfsr_seed_ok(32'(LFSR_SEED))) begin : g_zero_lfsr_seed_unsupported
    end

    // Entries already held plus the one whose data arrives this cycle.
    assign occupancy = count + {{PTR_BITS{1'b0}}, inflight};

    // Request only when a slot is guaranteed for the returning word; no m_ready path.
    assign rd_en   = !empty && !rd_rst && (occupancy < DEPTH_VAL);
    assign m_valid = (count != '0);
    assign pop     = m_valid && m_ready;
    // Gated so the stream shows zeros while the buffer is empty (including after reset).
    assign m_data  = m_valid ? buffer[rd_ptr] : '0;

    // Capture returning FIFO data into the ring buffer.
    // NOTE: the storage array is deliberately not reset; pointers and count
    // define which entries are live, so stale contents are never observed.
    always_ff @(posedge rd_clk) begin
        if (inflight) begin
            buffer[wr_ptr] <= Data_out;
        end
    end

    // Track the outstanding read, ring pointers, fill level and delivered-word count.
    always_ff @(posedge rd_clk) begin
        if (rd_rst) begin
            inflight   <= 1'b0;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count      <= '0;
            words_rcvd <= '0;
        end else begin
            inflight <= rd_en;
            if (inflight) begin
                wr_ptr <= wr_ptr + PTR_BITS'(1);
            end
            if (pop) begin
                rd_ptr     <= rd_ptr + PTR_BITS'(1);
                words_rcvd <= words_rcvd + CNT_BITS'(1);
            end
            case ({inflight, pop})
                2'b10:   count <= count + (PTR_BITS + 1)'(1);
                2'b01:   count <= count - (PTR_BITS + 1)'(1);
                default: count <= count;
            endcase
        end
    end

`ifdef FIFO_RD_SEQ_CHECK_EN
    logic [DATA_BITS-1:0] expected;
    logic                 mismatch;

    fifo_rd_lfsr #(
        .WIDTH (DATA_BITS),
        .SEED  (LFSR_SEED)
    ) u_lfsr (
        .clk     (rd_clk),
        .rst     (rd_rst),
        .advance (inflight),
        .value   (expected)
    );

    assign mismatch = inflight && (Data_out != expected);

    // Flag a mismatching capture for one cycle and keep a saturating tally.
    always_ff @(posedge rd_clk) begin
        if (rd_rst) begin
            seq_err   <= 1'b0;
            err_count <= '0;
        end else begin
            seq_err <= mismatch;
            if (mismatch && (err_count != '1)) begin
                err_count <= err_count + CNT_BITS'(1);
            end
        end
    end
`else
    assign seq_err   = 1'b0;
    assign err_count = '0;
`endif

endmodule
